// File: rtl/adc_packetizer.sv
// adc_packetizer: captures parallel ADC sample sets, optionally decimates them,
// buffers them in a small FIFO and emits fixed-length AXI-Stream packets.
// Single-shot or continuous capture; stop takes effect on a packet boundary.
module adc_packetizer #(
  parameter int CHANNELS   = 2,
  parameter int SAMPLE_W   = 16,
  parameter int LEN_W      = 24,
  parameter int DEC_W      = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         mode_cont,
  input  logic [LEN_W-1:0]             pkt_len,
  input  logic [DEC_W-1:0]             decim,
  input  logic                         s_valid,
  input  logic [CHANNELS*SAMPLE_W-1:0] s_data,
  output logic [CHANNELS*SAMPLE_W-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic                         busy,
  output logic                         overflow,
  output logic                         done
);

  localparam int DW = CHANNELS * SAMPLE_W;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  // Each FIFO entry carries {tlast, sample set}.
  logic [DW:0]      r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_beat_cnt;
  logic [DEC_W-1:0] r_decim;
  logic [DEC_W-1:0] r_dec_cnt;
  logic             r_mode_cont;
  logic             r_stop_req;
  logic             r_overflow;
  logic             r_done;

  logic [AW:0]      w_level;
  logic             w_empty;
  logic             w_full;
  logic             w_start_ok;
  logic             w_accept;
  logic             w_wr_en;
  logic             w_rd_en;
  logic             w_last_beat;
  logic             w_stop_now;
  logic             w_end_capture;
  logic [DW:0]      w_head;

  // Pointers carry one extra bit so full and empty are distinguishable.
  // Full is judged before any same-cycle read, so a write into a full FIFO is
  // dropped even if the head retires in that cycle.
  assign w_level       = r_wr_ptr - r_rd_ptr;
  assign w_empty       = (w_level == '0);
  assign w_full        = (w_level == (AW+1)'(FIFO_DEPTH));
  assign w_start_ok    = (r_state == ST_IDLE) && start && (pkt_len != '0);
  assign w_accept      = (r_state == ST_RUN) && s_valid && (r_dec_cnt == '0);
  assign w_wr_en       = w_accept && !w_full;
  assign w_rd_en       = !w_empty && m_axis_tready;
  assign w_last_beat   = (r_beat_cnt == r_len - LEN_W'(1));
  assign w_stop_now    = (r_state == ST_RUN) && r_mode_cont && stop;
  // A stop arriving together with the tlast write ends capture on that packet.
  assign w_end_capture = w_wr_en && w_last_beat && (!r_mode_cont || r_stop_req || stop);

  // Head of FIFO is read straight from storage; zeroed while empty so the
  // stream outputs are quiet after reset.
  assign w_head        = r_mem[r_rd_ptr[AW-1:0]];
  assign m_axis_tvalid = !w_empty;
  assign m_axis_tdata  = w_empty ? '0 : w_head[DW-1:0];
  assign m_axis_tlast  = w_empty ? 1'b0 : w_head[DW];
  assign busy          = (r_state != ST_IDLE);
  assign overflow      = r_overflow;
  assign done          = r_done;

  // Next-state selection for the capture controller.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_start_ok)    w_state_nxt = ST_RUN;
      ST_RUN:   if (w_end_capture) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_empty)       w_state_nxt = ST_IDLE;
      default:                     w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Capture parameters, decimation/beat counters, stop request and status flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_len       <= '0;
      r_decim     <= '0;
      r_mode_cont <= 1'b0;
      r_beat_cnt  <= '0;
      r_dec_cnt   <= '0;
      r_stop_req  <= 1'b0;
      r_overflow  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DRAIN) && w_empty;
      if (w_start_ok) begin
        r_len       <= pkt_len;
        r_decim     <= decim;
        r_mode_cont <= mode_cont;
        r_beat_cnt  <= '0;
        r_dec_cnt   <= '0;
        r_stop_req  <= 1'b0;
        r_overflow  <= 1'b0;
      end else if (r_state == ST_RUN) begin
        if (s_valid)
          r_dec_cnt <= (r_dec_cnt == r_decim) ? '0 : r_dec_cnt + DEC_W'(1);
        if (w_stop_now)
          r_stop_req <= 1'b1;
        // A dropped sample leaves the beat count alone so packets keep their length.
        if (w_accept && w_full)
          r_overflow <= 1'b1;
        if (w_wr_en)
          r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + LEN_W'(1);
      end
    end
  end

  // FIFO pointers; reset discards any buffered beats.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the pointers alone define valid content,
    // which keeps the array as plain RAM.
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= {w_last_beat, s_data};
  end

endmodule

// File: doc/adc_packetizer.md
# adc_packetizer

Multi-channel ADC capture packetizer feeding the digitizer's AXI-Stream path into the AXI DMA (S2MM). It accepts parallel samples from CHANNELS ADC channels already in the fabric clock domain, optionally decimates them, buffers them in a small FIFO and emits AXI-Stream packets of programmable length with TLAST. It supports single-shot and continuous capture, which the current one-packet-per-start capture path does not.

## Interface
- CHANNELS, 2, number of ADC channels sampled together
- SAMPLE_W, 16, bits per channel sample
- LEN_W, 24, width of packet-length register (beats)
- DEC_W, 8, width of decimation register
- FIFO_DEPTH, 16, output buffer depth in beats (power of 2, ≥4)
- clk  in  1  single clock for all logic
- resetn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse, begins capture
- stop  in  1  one-cycle pulse, ends continuous capture at next packet boundary
- mode_cont  in  1  0 = single packet, 1 = continuous packets; latched at start
- pkt_len  in  LEN_W  beats per packet; latched at start
- decim  in  DEC_W  keep 1 of every decim+1 valid samples; latched at start
- s_valid  in  1  new sample set present on s_data
- s_data  in  CHANNELS*SAMPLE_W  channel 0 in LSBs
- m_axis_tdata  out  CHANNELS*SAMPLE_W  packed sample set
- m_axis_tvalid  out  1  AXI-Stream valid
- m_axis_tready  in  1  AXI-Stream ready
- m_axis_tlast  out  1  last beat of packet
- busy  out  1  high in RUN or DRAIN
- overflow  out  1  sticky, sample dropped because FIFO full
- done  out  1  one-cycle pulse on DRAIN→IDLE

## Operation
- States IDLE, RUN, DRAIN. Reset → IDLE; all outputs 0, FIFO emptied, counters cleared.
- IDLE: start with pkt_len≠0 → RUN; latch pkt_len, decim, mode_cont; clear overflow, beat counter, decimation counter, stop request. start with pkt_len=0 ignored.
- RUN: each s_valid advances decimation counter (wraps at decim); sample accepted when s_valid and counter==0. First s_valid after entering RUN is accepted. decim=0 → every sample accepted.
- Accepted sample written to FIFO with tlast flag = (beat counter == len-1). Beat counter increments per write, wraps to 0 after tlast write.
- FIFO full at accept: sample dropped, overflow set, beat counter and tlast placement unchanged (packets stay exactly pkt_len beats).
- Single mode: after tlast write → DRAIN.
- Continuous: stop sets stop request; after next tlast write with request set → DRAIN. stop coincident with tlast write → DRAIN that cycle. stop in IDLE/DRAIN or in single mode ignored.
- start while busy ignored. Changes to pkt_len/decim/mode_cont while busy have no effect.
- DRAIN: no samples accepted; FIFO empty (tvalid low) → IDLE with done pulse.
- Output: m_axis_tvalid = FIFO not empty; beat retires when tvalid&tready. tdata/tlast stable while tvalid&!tready.
- Reset mid-packet: FIFO content discarded, no partial TLAST emitted.

## Timing
- Accepted sample in cycle N → m_axis_tvalid at earliest cycle N+1 (registered FIFO write, FIFO output combinational from storage).
- Full capacity FIFO_DEPTH beats; simultaneous read and write when full: write still dropped (full evaluated pre-read).
- done asserted exactly one cycle, same cycle busy falls.
- Sustained throughput 1 beat/clk with tready high and decim=0.

## Test plan
- Single shot: pkt_len=8, decim=0, counter data 0..7 with s_valid every cycle, tready=1 → 8 beats 0..7, tlast on beat 7 only, done pulse, busy low, overflow 0.
- Decimation: pkt_len=4, decim=2, input 0..11 → beats 0,3,6,9, tlast on 9.
- Continuous + stop: pkt_len=4, mode_cont=1, stop pulsed after 6th accepted sample → exactly 8 beats, tlast on 4th and 8th, then done.
- Backpressure overflow: FIFO_DEPTH=16, tready=0, pkt_len=32, 20 samples → overflow=1 after 17th sample, 16 beats 0..15 emitted after tready=1; tlast still at 32nd accepted beat.
- Reset mid-packet: resetn low after 3 of 8 beats → outputs 0 asynchronously; new start yields clean 8-beat packet.
- Ignored controls: start with pkt_len=0 → stays IDLE; start during RUN → no restart, original length honored.
